// File: rtl/vga_timing_driver.sv
// 640x480@60 Hz VGA timing generator with RGB332 -> RGB888 expansion and a registered, aligned output stage.
// Optional colour-bar generator (input test_mode) is compiled in when VGA_TEST_PATTERN_EN is defined.
module vga_timing_driver #(
  parameter int CLK_DIV   = 2,
  parameter int H_VISIBLE = 640,
  parameter int H_FP      = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BP      = 48,
  parameter int V_VISIBLE = 480,
  parameter int V_FP      = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BP      = 33
) (
  input  logic       clk,
  input  logic       rst_n,
`ifdef VGA_TEST_PATTERN_EN
  input  logic       test_mode,
`endif
  input  logic [7:0] color_in,
  output logic [9:0] current_pixel_x,
  output logic [9:0] current_pixel_y,
  output logic       pixel_tick,
  output logic       frame_start,
  output logic [7:0] vga_r,
  output logic [7:0] vga_g,
  output logic [7:0] vga_b,
  output logic       vga_hs,
  output logic       vga_vs,
  output logic       vga_blank_n,
  output logic       vga_sync_n,
  output logic       vga_clk
);

  localparam int H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;
  localparam int DIV_W   = $clog2(CLK_DIV);

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(CLK_DIV / 2);
  localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS    = 10'(H_VISIBLE);
  localparam logic [9:0] V_VIS    = 10'(V_VISIBLE);
  localparam logic [9:0] HS_FIRST = 10'(H_VISIBLE + H_FP);
  localparam logic [9:0] HS_LAST  = 10'(H_VISIBLE + H_FP + H_SYNC - 1);
  localparam logic [9:0] VS_FIRST = 10'(V_VISIBLE + V_FP);
  localparam logic [9:0] VS_LAST  = 10'(V_VISIBLE + V_FP + V_SYNC - 1);

  logic [DIV_W-1:0] r_div;
  logic [DIV_W-1:0] w_div_next;
  logic [9:0]       r_h;
  logic [9:0]       r_v;
  logic             w_tick;
  logic             w_h_last;
  logic             w_v_last;
  logic             w_visible;
  logic             w_hs_active;
  logic             w_vs_active;
  logic [23:0]      w_rgb;
  logic [23:0]      r_rgb;
  logic             r_hs;
  logic             r_vs;
  logic             r_blank_n;
  logic             r_vga_clk;

  assign w_tick     = (r_div == DIV_LAST);
  assign w_div_next = w_tick ? '0 : r_div + DIV_W'(1);
  assign w_h_last   = (r_h == H_LAST);
  assign w_v_last   = (r_v == V_LAST);

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_div     <= '0;
      r_vga_clk <= 1'b0;
    end else begin
      r_div     <= w_div_next;
      // Registered from the next divider value so vga_clk tracks div with no extra lag.
      r_vga_clk <= (w_div_next >= DIV_HALF);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_h <= '0;
      r_v <= '0;
    end else if (w_tick) begin
      if (w_h_last) begin
        r_h <= '0;
        r_v <= w_v_last ? '0 : r_v + 10'd1;
      end else begin
        r_h <= r_h + 10'd1;
      end
    end
  end

  assign w_visible   = (r_h < H_VIS) && (r_v < V_VIS);
  assign w_hs_active = (r_h >= HS_FIRST) && (r_h <= HS_LAST);
  assign w_vs_active = (r_v >= VS_FIRST) && (r_v <= VS_LAST);

  // NOTE: w_rgb gets a default before any branch so no path leaves it unassigned (no latch).
  always_comb begin
    w_rgb = '0;
    if (w_visible) begin
`ifdef VGA_TEST_PATTERN_EN
      if (test_mode) begin
        logic [2:0] w_bar;
        w_bar = 3'(r_h / 10'd80);
        w_rgb = {{8{w_bar[2]}}, {8{w_bar[1]}}, {8{w_bar[0]}}};
      end else begin
        w_rgb = {color_in[7:5], color_in[7:5], color_in[7:6],
                 color_in[4:2], color_in[4:2], color_in[4:3],
                 {4{color_in[1:0]}}};
      end
`else
      w_rgb = {color_in[7:5], color_in[7:5], color_in[7:6],
               color_in[4:2], color_in[4:2], color_in[4:3],
               {4{color_in[1:0]}}};
`endif
    end
  end

  // Output stage is computed from the pre-increment counters, so all video lags the coordinates by one pixel.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rgb     <= '0;
      r_hs      <= 1'b1;
      r_vs      <= 1'b1;
      r_blank_n <= 1'b0;
    end else if (w_tick) begin
      r_rgb     <= w_rgb;
      r_hs      <= ~w_hs_active;
      r_vs      <= ~w_vs_active;
      r_blank_n <= w_visible;
    end
  end

  assign current_pixel_x = r_h;
  assign current_pixel_y = r_v;
  assign pixel_tick      = w_tick;
  assign frame_start     = w_tick && w_h_last && w_v_last;
  assign vga_r           = r_rgb[23:16];
  assign vga_g           = r_rgb[15:8];
  assign vga_b           = r_rgb[7:0];
  assign vga_hs          = r_hs;
  assign vga_vs          = r_vs;
  assign vga_blank_n     = r_blank_n;
  assign vga_sync_n      = 1'b0;
  assign vga_clk         = r_vga_clk;

endmodule

// File: tb/tb_vga_timing_driver.sv
// Self-checking bench for vga_timing_driver: spec-level timing model, per-pixel output scoreboard,
// RGB expansion table and hand-written line/frame/reset sequences. Vertical timing is shortened to keep frames short.
module tb_vga_timing_driver;

  localparam int CLK_DIV   = 2;
  localparam int H_VISIBLE = 640;
  localparam int H_FP      = 16;
  localparam int H_SYNC    = 96;
  localparam int H_BP      = 48;
  localparam int V_VISIBLE = 12;
  localparam int V_FP      = 2;
  localparam int V_SYNC    = 2;
  localparam int V_BP      = 2;
  localparam int H_TOTAL   = H_VISIBLE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL   = V_VISIBLE + V_FP + V_SYNC + V_BP;
  localparam int FRAME_CLKS = H_TOTAL * V_TOTAL * CLK_DIV;
  localparam int WAIT_LIMIT = 2 * FRAME_CLKS;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] color_in;
  logic [9:0] current_pixel_x, current_pixel_y;
  logic       pixel_tick, frame_start;
  logic [7:0] vga_r, vga_g, vga_b;
  logic       vga_hs, vga_vs, vga_blank_n, vga_sync_n, vga_clk;

  int n_checks = 0;
  int n_errors = 0;
  bit mon_en   = 1'b0;

  always #5 clk = ~clk;

  vga_timing_driver #(
    .CLK_DIV(CLK_DIV), .H_VISIBLE(H_VISIBLE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_VISIBLE(V_VISIBLE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
`ifdef VGA_TEST_PATTERN_EN
    .test_mode(1'b0),
`endif
    .color_in(color_in),
    .current_pixel_x(current_pixel_x),
    .current_pixel_y(current_pixel_y),
    .pixel_tick(pixel_tick),
    .frame_start(frame_start),
    .vga_r(vga_r),
    .vga_g(vga_g),
    .vga_b(vga_b),
    .vga_hs(vga_hs),
    .vga_vs(vga_vs),
    .vga_blank_n(vga_blank_n),
    .vga_sync_n(vga_sync_n),
    .vga_clk(vga_clk)
  );

  task automatic finish_sim();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
      if (n_errors >= 50) finish_sim();
    end
  endtask

  // Reference timing model: divider and raster counters.
  int m_div, m_h, m_v;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_div <= 0; m_h <= 0; m_v <= 0;
    end else if (m_div == CLK_DIV - 1) begin
      m_div <= 0;
      if (m_h == H_TOTAL - 1) begin
        m_h <= 0;
        m_v <= (m_v == V_TOTAL - 1) ? 0 : m_v + 1;
      end else begin
        m_h <= m_h + 1;
      end
    end else begin
      m_div <= m_div + 1;
    end
  end

  // Expected {rgb, hs, vs, blank_n} for a pixel at (h, v) with colour c.
  function automatic logic [26:0] exp_out(input int h, input int v, input logic [7:0] c);
    logic vis, hs, vs;
    logic [23:0] rgb;
    vis = (h < H_VISIBLE) && (v < V_VISIBLE);
    hs  = !((h >= H_VISIBLE + H_FP) && (h < H_VISIBLE + H_FP + H_SYNC));
    vs  = !((v >= V_VISIBLE + V_FP) && (v < V_VISIBLE + V_FP + V_SYNC));
    rgb = vis ? {c[7:5], c[7:5], c[7:6], c[4:2], c[4:2], c[4:3], {4{c[1:0]}}} : 24'h0;
    return {rgb, hs, vs, vis};
  endfunction

  logic [26:0] sb[$];

  always @(negedge clk) begin
    if (!rst_n) begin
      sb.delete();
    end else if (mon_en) begin
      check("timing", {current_pixel_x, current_pixel_y, pixel_tick, vga_clk, frame_start},
            {10'(m_h), 10'(m_v), (m_div == CLK_DIV - 1), (m_div >= CLK_DIV / 2),
             (m_div == CLK_DIV - 1) && (m_h == H_TOTAL - 1) && (m_v == V_TOTAL - 1)});
      if (sb.size() > 0) begin
        logic [26:0] e;
        e = sb.pop_front();
        check("video", {vga_r, vga_g, vga_b, vga_hs, vga_vs, vga_blank_n}, e);
      end
      if (m_div == CLK_DIV - 1) sb.push_back(exp_out(m_h, m_v, color_in));
    end
  end

  task automatic pixel_start();
    do begin @(posedge clk); #1; end while (m_div != 0);
  endtask

  task automatic wait_xy(input int x, input int y);
    int n = 0;
    while (!(m_h == x && m_v == y && m_div == 0) && n < WAIT_LIMIT) begin
      @(posedge clk); #1; n++;
    end
    if (n >= WAIT_LIMIT) check("wait_xy_timeout", 0, 1);
  endtask

  task automatic check_reset(input string name);
    check(name, {current_pixel_x, current_pixel_y, vga_r, vga_g, vga_b, vga_hs, vga_vs,
                 vga_blank_n, vga_clk, pixel_tick, frame_start, vga_sync_n},
          {10'd0, 10'd0, 24'h0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0});
  endtask

  // Starts at the pixel-period boundary of x=0 and counts hs-low output periods over one line.
  task automatic measure_hs_line(input string name);
    int cnt = 0;
    for (int i = 0; i < H_TOTAL; i++) begin
      if (!vga_hs) cnt++;
      pixel_start();
    end
    check(name, cnt, H_SYNC);
  endtask

  typedef struct {
    logic [7:0]  c;
    logic [23:0] rgb;
  } vec_t;

  initial begin
    vec_t vecs[8];
    int n, vs_cnt;

    vecs[0] = '{8'hE0, 24'hFF_00_00};
    vecs[1] = '{8'hFB, 24'hFF_DB_FF};
    vecs[2] = '{8'h00, 24'h00_00_00};
    vecs[3] = '{8'hFF, 24'hFF_FF_FF};
    vecs[4] = '{8'h1C, 24'h00_FF_00};
    vecs[5] = '{8'h03, 24'h00_00_FF};
    vecs[6] = '{8'h92, 24'h92_92_AA};
    vecs[7] = '{8'h49, 24'h49_49_55};

    rst_n    = 1'b0;
    color_in = vecs[0].c;
    repeat (5) @(posedge clk);
    #1 check_reset("reset_hold");

    @(negedge clk) rst_n = 1'b1;
    mon_en = 1'b1;
    @(posedge clk); #1;
    check("first_tick", {pixel_tick, current_pixel_x}, {1'b1, 10'd0});

    for (int i = 0; i < 8; i++) begin
      pixel_start();
      if (i == 0) check("x_after_first_tick", current_pixel_x, 10'd1);
      check($sformatf("rgb_vec%0d", i), {vga_r, vga_g, vga_b, vga_blank_n}, {vecs[i].rgb, 1'b1});
      if (i < 7) color_in = vecs[i + 1].c;
    end
    color_in = 8'hFF;

    // Horizontal boundaries on line 0 (outputs show the previous pixel).
    wait_xy(640, 0);
    check("blank_at_x640", vga_blank_n, 1'b1);
    pixel_start();
    check("blank_at_x641", vga_blank_n, 1'b0);
    wait_xy(656, 0);
    check("hs_at_x656", vga_hs, 1'b1);
    pixel_start();
    check("hs_at_x657", vga_hs, 1'b0);
    wait_xy(H_TOTAL - 1, 0);
    pixel_start();
    check("line_wrap", {current_pixel_x, current_pixel_y}, {10'd0, 10'd1});
    measure_hs_line("hs_low_periods_line1");

    wait_xy(700, 10);
    pixel_start();
    check("offscreen_blank", {vga_r, vga_g, vga_b, vga_blank_n}, 25'h0);

    // Full frame between two frame_start pulses.
    n = 0;
    while (!frame_start && n < WAIT_LIMIT) begin @(posedge clk); #1; n++; end
    check("frame_start_seen", frame_start, 1'b1);
    check("frame_start_xy", {current_pixel_x, current_pixel_y}, {10'(H_TOTAL - 1), 10'(V_TOTAL - 1)});
    n = 0; vs_cnt = 0;
    do begin
      @(posedge clk); #1; n++;
      if (n == 1) begin
        check("frame_start_width", frame_start, 1'b0);
        check("frame_restart_xy", {current_pixel_x, current_pixel_y}, 20'd0);
      end
      if (m_div == 0 && !vga_vs) vs_cnt++;
    end while (!frame_start && n < WAIT_LIMIT);
    check("frame_length_clks", n, FRAME_CLKS);
    check("vs_low_periods", vs_cnt, V_SYNC * H_TOTAL);

    // Mid-frame reset.
    wait_xy(300, 5);
    rst_n = 1'b0;
    #1 check_reset("reset_mid_immediate");
    repeat (3) @(posedge clk);
    #1 check_reset("reset_mid_hold");
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    check("restart_first_tick", {pixel_tick, current_pixel_x, current_pixel_y}, {1'b1, 20'd0});
    wait_xy(656, 0);
    check("restart_hs_x656", vga_hs, 1'b1);
    pixel_start();
    check("restart_hs_x657", vga_hs, 1'b0);
    wait_xy(0, 1);
    measure_hs_line("restart_hs_low_periods");

    finish_sim();
  end

  initial begin
    #(95000 * 10);
    check("global_timeout", 0, 1);
    finish_sim();
  end

endmodule
